// File: rtl/mem_wr_buffer.sv
// mem_wr_buffer: store path from Excute to the data cache.
// Decodes byte/half/word/dword stores into lane-aligned data plus an
// active-low bit mask, rejects misaligned stores with a one-cycle pulse,
// queues legal stores in a DEPTH-entry FIFO drained over valid/ready, and
// reports whether a load address hits any queued store lane.
// Optional feature: define MEM_WR_MERGE_EN to let a store fold into the
// youngest queued entry (never the head) when both target the same lane.
module mem_wr_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    iStValid,
    input  logic [1:0]              iStSize,
    input  logic [ADDR_WIDTH-1:0]   iStAddr,
    input  logic [DATA_WIDTH-1:0]   iStData,
    output logic                    oStReady,
    output logic                    oMisalign,
    input  logic                    iFlush,
    output logic                    oDcValid,
    input  logic                    iDcReady,
    output logic [ADDR_WIDTH-1:0]   oDcAddr,
    output logic [DATA_WIDTH-1:0]   oDcData,
    output logic [DATA_WIDTH-1:0]   oDcMask,
    input  logic [ADDR_WIDTH-1:0]   iLdAddr,
    output logic                    oLdHit,
    output logic [$clog2(DEPTH):0]  oCount
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Entry storage; validity is implied by head pointer and count.
    logic [ADDR_WIDTH-1:0] ent_addr [DEPTH];
    logic [DATA_WIDTH-1:0] ent_data [DEPTH];
    logic [DATA_WIDTH-1:0] ent_mask [DEPTH];

    logic [PTR_W-1:0]      head_reg, head_next;
    logic [PTR_W-1:0]      tail_reg, tail_next;
    logic [CNT_W-1:0]      count_reg, count_next;
    logic                  misalign_reg, misalign_next;
    logic [ADDR_WIDTH-1:0] out_addr_reg;
    logic [DATA_WIDTH-1:0] out_data_reg;
    logic [DATA_WIDTH-1:0] out_mask_reg;

    // Store decode
    logic [OFF_W-1:0]      st_off;
    logic                  st_legal;
    logic [NB-1:0]         size_bytes;
    logic [NB-1:0]         st_byte_en;
    logic [DATA_WIDTH-1:0] st_trim;
    logic [DATA_WIDTH-1:0] st_lane_data;
    logic [DATA_WIDTH-1:0] st_lane_mask;
    logic [ADDR_WIDTH-1:0] st_lane_addr;
    logic [ADDR_WIDTH-1:0] ld_lane_addr;
    logic                  unused_ld_off;

    // Handshake / control
    logic                  full;
    logic                  mergeable;
    logic                  push_fire;
    logic                  merge_fire;
    logic                  alloc;
    logic                  pop_fire;

    // Write port into the entry array (new entry or merge target)
    logic                  wr_en;
    logic [PTR_W-1:0]      wr_idx;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] wr_mask;

    logic [DEPTH-1:0]      hit_vec;

    assign st_off        = iStAddr[OFF_W-1:0];
    assign st_lane_addr  = {iStAddr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
    assign ld_lane_addr  = {iLdAddr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
    assign unused_ld_off = ^iLdAddr[OFF_W-1:0];

    // Alignment legality by access size; dword only fits a 64-bit lane
    always_comb begin
        st_legal = 1'b0;
        case (iStSize)
            2'b00:   st_legal = 1'b1;
            2'b01:   st_legal = ~iStAddr[0];
            2'b10:   st_legal = (iStAddr[1:0] == 2'b00);
            default: st_legal = (DATA_WIDTH == 64) && (iStAddr[2:0] == 3'b000);
        endcase
    end

    // Bytes covered by the access size, before shifting into the lane
    always_comb begin
        size_bytes = '0;
        for (int b = 0; b < NB; b++) begin
            size_bytes[b] = (32'(b) < (32'd1 << iStSize));
        end
    end

    assign st_byte_en = size_bytes << st_off;

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_byte
            assign st_trim[gi*8 +: 8]      = size_bytes[gi] ? iStData[gi*8 +: 8] : 8'h00;
            assign st_lane_mask[gi*8 +: 8] = {8{~st_byte_en[gi]}};
        end
    endgenerate

    assign st_lane_data = st_trim << {st_off, 3'b000};

    assign full = (count_reg == CNT_W'(DEPTH));

`ifdef MEM_WR_MERGE_EN
    logic [PTR_W-1:0] young_idx;
    assign young_idx = tail_reg - PTR_W'(1);
    // Youngest entry is a merge target only when it is not also the head
    assign mergeable = (count_reg >= CNT_W'(2)) && (ent_addr[young_idx] == st_lane_addr);
`else
    assign mergeable = 1'b0;
`endif

    assign oStReady   = !full || mergeable;
    assign push_fire  = iStValid && oStReady && st_legal && !iFlush;
    assign merge_fire = push_fire && mergeable;
    assign alloc      = push_fire && !mergeable;
    assign pop_fire   = (count_reg != '0) && iDcReady && !iFlush;

    // Select what the entry array writes this cycle: a fresh entry or a merge
    always_comb begin
        wr_en   = push_fire;
        wr_idx  = tail_reg;
        wr_data = st_lane_data;
        wr_mask = st_lane_mask;
`ifdef MEM_WR_MERGE_EN
        if (merge_fire) begin
            wr_idx  = young_idx;
            wr_data = (ent_data[young_idx] & st_lane_mask) | st_lane_data;
            wr_mask = ent_mask[young_idx] & st_lane_mask;
        end
`else
        if (merge_fire) begin
            wr_idx = tail_reg;
        end
`endif
    end

    // Pointer/count bookkeeping; flush wins over push and pop
    always_comb begin
        head_next     = head_reg + PTR_W'(pop_fire);
        tail_next     = tail_reg + PTR_W'(alloc);
        count_next    = count_reg + CNT_W'(alloc) - CNT_W'(pop_fire);
        misalign_next = iStValid && oStReady && !st_legal && !iFlush;
        if (iFlush) begin
            head_next  = head_reg;
            tail_next  = head_reg;
            count_next = '0;
        end
    end

    // Entry array writes; contents need no reset since count gates validity
    always_ff @(posedge clk) begin
        if (wr_en) begin
            ent_addr[wr_idx] <= st_lane_addr;
            ent_data[wr_idx] <= wr_data;
            ent_mask[wr_idx] <= wr_mask;
        end
    end

    // Control state and head-of-queue output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
            misalign_reg <= 1'b0;
            out_addr_reg <= '0;
            out_data_reg <= '0;
            out_mask_reg <= '1;
        end else begin
            head_reg     <= head_next;
            tail_reg     <= tail_next;
            count_reg    <= count_next;
            misalign_reg <= misalign_next;
            // Outputs follow the next head; they hold while the queue is empty
            if (!iFlush && (count_next != '0)) begin
                if (wr_en && (wr_idx == head_next)) begin
                    out_addr_reg <= st_lane_addr;
                    out_data_reg <= wr_data;
                    out_mask_reg <= wr_mask;
                end else begin
                    out_addr_reg <= ent_addr[head_next];
                    out_data_reg <= ent_data[head_next];
                    out_mask_reg <= ent_mask[head_next];
                end
            end
        end
    end

    // Load hazard: any valid entry (head included) in the same lane
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
            logic [PTR_W-1:0] rel;
            assign rel         = PTR_W'(gi) - head_reg;
            assign hit_vec[gi] = ({1'b0, rel} < count_reg) && (ent_addr[gi] == ld_lane_addr);
        end
    endgenerate

    assign oLdHit    = |hit_vec;
    assign oDcValid  = (count_reg != '0);
    assign oDcAddr   = out_addr_reg;
    assign oDcData   = out_data_reg;
    assign oDcMask   = out_mask_reg;
    assign oMisalign = misalign_reg;
    assign oCount    = count_reg;

endmodule

// File: tb/tb_mem_wr_buffer.sv
// Bench for mem_wr_buffer: queue-based reference model checked every cycle,
// directed scenarios with hand-computed values, then randomized traffic.
// Honours MEM_WR_MERGE_EN when the design is built with it.
module tb_mem_wr_buffer;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 4;
    localparam int NB    = DW / 8;
`ifdef MEM_WR_MERGE_EN
    localparam bit MERGE = 1'b1;
`else
    localparam bit MERGE = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          iStValid;
    logic [1:0]    iStSize;
    logic [AW-1:0] iStAddr;
    logic [DW-1:0] iStData;
    logic          oStReady;
    logic          oMisalign;
    logic          iFlush;
    logic          oDcValid;
    logic          iDcReady;
    logic [AW-1:0] oDcAddr;
    logic [DW-1:0] oDcData;
    logic [DW-1:0] oDcMask;
    logic [AW-1:0] iLdAddr;
    logic          oLdHit;
    logic [$clog2(DEPTH):0] oCount;

    always #5 clk = ~clk;

    mem_wr_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .iStValid(iStValid), .iStSize(iStSize), .iStAddr(iStAddr), .iStData(iStData),
        .oStReady(oStReady), .oMisalign(oMisalign), .iFlush(iFlush),
        .oDcValid(oDcValid), .iDcReady(iDcReady), .oDcAddr(oDcAddr),
        .oDcData(oDcData), .oDcMask(oDcMask), .iLdAddr(iLdAddr),
        .oLdHit(oLdHit), .oCount(oCount)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [DW-1:0] mask;
    } ent_t;

    ent_t          q[$];
    logic [AW-1:0] last_addr = '0;
    logic [DW-1:0] last_data = '0;
    logic [DW-1:0] last_mask = '1;
    logic          exp_mis   = 1'b0;
    int            n_checks  = 0;
    int            n_pass    = 0;

    function automatic logic [AW-1:0] lane(input logic [AW-1:0] a);
        return a & ~AW'(NB - 1);
    endfunction

    function automatic logic legal(input logic [1:0] sz, input logic [AW-1:0] a);
        case (sz)
            2'd0:    return 1'b1;
            2'd1:    return a[0] == 1'b0;
            2'd2:    return a[1:0] == 2'b00;
            default: return (DW == 64) && (a[2:0] == 3'b000);
        endcase
    endfunction

    // Place the low 2^sz bytes of d at the address offset within the lane
    task automatic build(input logic [1:0] sz, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         output logic [DW-1:0] data, output logic [DW-1:0] mask);
        int n;
        int off;
        data = '0;
        mask = '1;
        n    = 1 << sz;
        off  = int'(a % NB);
        for (int k = 0; k < n; k++) begin
            if ((off + k) < NB && (k * 8) < DW) begin
                data[(off + k) * 8 +: 8] = d[k * 8 +: 8];
                mask[(off + k) * 8 +: 8] = 8'h00;
            end
        end
    endtask

    function automatic logic model_mergeable(input logic [AW-1:0] a);
        return MERGE && (q.size() >= 2) && (q[q.size() - 1].addr == lane(a));
    endfunction

    function automatic logic model_hit(input logic [AW-1:0] ld);
        foreach (q[i]) if (q[i].addr == lane(ld)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // One cycle: drive inputs, check combinational outputs, advance model,
    // then check registered outputs after the edge.
    task automatic step(input logic v, input logic [1:0] sz, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic fl, input logic rdy,
                        input logic [AW-1:0] ld);
        logic          exp_rdy;
        logic          pop;
        logic [DW-1:0] nd;
        logic [DW-1:0] nm;
        iStValid = v; iStSize = sz; iStAddr = a; iStData = d;
        iFlush = fl; iDcReady = rdy; iLdAddr = ld;
        #1;
        exp_rdy = (q.size() != DEPTH) || model_mergeable(a);
        chk("st_ready", oStReady, exp_rdy);
        chk("ld_hit", oLdHit, model_hit(ld));
        pop = (q.size() != 0) && rdy && !fl;
        if (fl) begin
            q.delete();
            exp_mis = 1'b0;
            $display("txn flush");
        end else begin
            exp_mis = v && exp_rdy && !legal(sz, a);
            if (v && exp_rdy && legal(sz, a)) begin
                build(sz, a, d, nd, nm);
                if (model_mergeable(a)) begin
                    q[q.size() - 1].data = (q[q.size() - 1].data & nm) | nd;
                    q[q.size() - 1].mask = q[q.size() - 1].mask & nm;
                    $display("txn merge addr=%h data=%h mask=%h", lane(a), nd, nm);
                end else begin
                    q.push_back('{addr: lane(a), data: nd, mask: nm});
                    $display("txn push addr=%h data=%h mask=%h", lane(a), nd, nm);
                end
            end else if (v && exp_rdy) begin
                $display("txn reject size=%0d addr=%h", sz, a);
            end
            if (pop) begin
                $display("txn pop addr=%h data=%h mask=%h", q[0].addr, q[0].data, q[0].mask);
                q.pop_front();
            end
        end
        @(posedge clk);
        @(negedge clk);
        if (q.size() != 0) begin
            last_addr = q[0].addr;
            last_data = q[0].data;
            last_mask = q[0].mask;
        end
        chk("count", oCount, q.size());
        chk("dc_valid", oDcValid, q.size() != 0);
        chk("dc_addr", oDcAddr, last_addr);
        chk("dc_data", oDcData, last_data);
        chk("dc_mask", oDcMask, last_mask);
        chk("misalign", oMisalign, exp_mis);
    endtask

    task automatic idle(input logic rdy, input logic [AW-1:0] ld);
        step(1'b0, 2'd0, '0, '0, 1'b0, rdy, ld);
    endtask

    initial begin
        rst_n = 1'b0;
        iStValid = 1'b0; iStSize = '0; iStAddr = '0; iStData = '0;
        iFlush = 1'b0; iDcReady = 1'b0; iLdAddr = '0;
        repeat (3) @(negedge clk);
        chk("rst_valid", oDcValid, 0);
        chk("rst_misalign", oMisalign, 0);
        chk("rst_data", oDcData, 0);
        chk("rst_mask", oDcMask, 64'hFFFF_FFFF);
        chk("rst_addr", oDcAddr, 0);
        chk("rst_count", oCount, 0);
        chk("rst_ready", oStReady, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // SB at 0x1003 lands in the top byte of lane 0x1000
        step(1'b1, 2'd0, 32'h1003, 32'hAB, 1'b0, 1'b1, '0);
        chk("sb_valid", oDcValid, 1);
        chk("sb_addr", oDcAddr, 32'h1000);
        chk("sb_data", oDcData, 32'hAB00_0000);
        chk("sb_mask", oDcMask, 32'h00FF_FFFF);
        idle(1'b1, '0);
        chk("sb_drained", oCount, 0);

        // Misaligned half and an unsupported dword
        step(1'b1, 2'd1, 32'h2001, 32'h1234, 1'b0, 1'b1, '0);
        chk("sh_mis", oMisalign, 1);
        chk("sh_count", oCount, 0);
        idle(1'b1, '0);
        chk("mis_pulse_end", oMisalign, 0);
        step(1'b1, 2'd3, 32'h0, 32'h55, 1'b0, 1'b1, '0);
        chk("sd_mis", oMisalign, 1);
        idle(1'b1, '0);

        // Fill with the cache stalled, hold a fifth store, check load hits
        for (int i = 0; i < 4; i++)
            step(1'b1, 2'd2, 32'h3000 + i * 16, i + 1, 1'b0, 1'b0, 32'h3002);
        chk("full_count", oCount, 4);
        step(1'b1, 2'd2, 32'h4000, 32'h99, 1'b0, 1'b0, 32'h3002);
        chk("full_ready", oStReady, 0);
        chk("full_nomis", oMisalign, 0);
        chk("full_head", oDcData, 32'h1);
        chk("hit_3002", oLdHit, 1);
        idle(1'b0, 32'h3004);
        chk("miss_3004", oLdHit, 0);
        idle(1'b1, '0);
        chk("drain_order", oDcAddr, 32'h3010);
        repeat (3) idle(1'b1, '0);
        for (int i = 0; i < 6; i++)
            step(1'b1, 2'd2, 32'h6000 + i * 4, i, 1'b0, i[0], '0);
        repeat (6) idle(1'b1, '0);

        // Flush with a simultaneous store
        for (int i = 0; i < 3; i++)
            step(1'b1, 2'd2, 32'h5000 + i * 4, i, 1'b0, 1'b0, '0);
        step(1'b1, 2'd2, 32'h5100, 32'h77, 1'b1, 1'b1, '0);
        chk("flush_count", oCount, 0);
        chk("flush_valid", oDcValid, 0);
        chk("flush_nomis", oMisalign, 0);

        // Byte stores into one lane: merged or separate depending on build
        step(1'b1, 2'd2, 32'h100, 32'hDEAD_BEEF, 1'b0, 1'b0, '0);
        step(1'b1, 2'd0, 32'h104, 32'h11, 1'b0, 1'b0, '0);
        step(1'b1, 2'd0, 32'h105, 32'h22, 1'b0, 1'b0, '0);
        idle(1'b1, '0);
`ifdef MEM_WR_MERGE_EN
        chk("merge_count", oCount, 1);
        chk("merge_data", oDcData, 32'h0000_2211);
        chk("merge_mask", oDcMask, 32'hFFFF_0000);
`else
        chk("nomerge_count", oCount, 2);
        chk("nomerge_data", oDcData, 32'h0000_0011);
        chk("nomerge_mask", oDcMask, 32'hFFFF_FF00);
`endif
        repeat (3) idle(1'b1, '0);

        // Randomized traffic on a few lanes to exercise hits, wrap and merges
        for (int n = 0; n < 3000; n++) begin
            logic [AW-1:0] ra;
            logic [AW-1:0] rl;
            ra = 32'h100 + 32'($urandom_range(0, 2)) * 4 + 32'($urandom_range(0, 3));
            rl = 32'h100 + 32'($urandom_range(0, 3)) * 4 + 32'($urandom_range(0, 3));
            step(($urandom % 4) != 0, 2'($urandom % 4), ra, $urandom,
                 ($urandom % 40) == 0, ($urandom % 3) == 0, rl);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
